// File: rtl/tone_bank.sv
// Multi-voice square-wave tone generator with per-voice note timers and a
// 1-bit PWM mix of all voices for a single speaker pin.
module tone_bank #(
   parameter int  CLK_F    = 32,
   parameter int  CHANNELS = 4,
   parameter int  PERIOD_W = 20,
   parameter int  DUR_W    = 16,
   localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                wr_en,
   input  logic [CW-1:0]       wr_chan,
   input  logic [PERIOD_W-1:0] wr_period,
   input  logic [DUR_W-1:0]    wr_dur,
   output logic [CHANNELS-1:0] tone_out,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] done,
   output logic                mix_out
);

   localparam int            PW       = (CLK_F > 1) ? $clog2(CLK_F) : 1;
   localparam int            SW       = $clog2(CHANNELS + 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_F - 1);
   localparam logic [9:0]    MS_LAST  = 10'd999;

   function automatic logic [SW-1:0] popcount(input logic [CHANNELS-1:0] v);
      logic [SW-1:0] s;
      s = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         s = s + SW'(v[i]);
      end
      return s;
   endfunction

   logic [PW-1:0] pre_cnt;
   logic [9:0]    ms_cnt;
   logic          us_tick;
   logic          ms_tick;

   assign us_tick = (pre_cnt == PRE_LAST);
   assign ms_tick = us_tick && (ms_cnt == MS_LAST);

   // Global timebase: free-running, never disturbed by writes.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pre_cnt <= '0;
         ms_cnt  <= '0;
      end else if (us_tick) begin
         pre_cnt <= '0;
         ms_cnt  <= (ms_cnt == MS_LAST) ? 10'd0 : ms_cnt + 10'd1;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
      logic [PERIOD_W-1:0] period;
      logic [PERIOD_W-1:0] hp_cnt;
      logic [DUR_W-1:0]    dur_cnt;
      logic                timed;
      logic                tone_r;
      logic                busy_r;
      logic                done_r;
      logic                hit;

      // Channel numbers at or above CHANNELS match no voice and are dropped.
      assign hit = wr_en && (wr_chan == CW'(g));

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            period  <= '0;
            hp_cnt  <= '0;
            dur_cnt <= '0;
            timed   <= 1'b0;
            tone_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
         end else begin
            done_r <= 1'b0;
            if (hit) begin
               tone_r <= 1'b0;
               if (wr_period != '0) begin
                  period  <= wr_period;
                  hp_cnt  <= '0;
                  dur_cnt <= wr_dur;
                  timed   <= (wr_dur != '0);
                  busy_r  <= 1'b1;
               end else begin
                  timed  <= 1'b0;
                  busy_r <= 1'b0;
               end
            end else if (busy_r) begin
               if (ms_tick && timed && (dur_cnt == DUR_W'(1))) begin
                  dur_cnt <= '0;
                  busy_r  <= 1'b0;
                  tone_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  if (ms_tick && timed) begin
                     dur_cnt <= dur_cnt - DUR_W'(1);
                  end
                  if (us_tick) begin
                     if (hp_cnt == period - PERIOD_W'(1)) begin
                        hp_cnt <= '0;
                        tone_r <= ~tone_r;
                     end else begin
                        hp_cnt <= hp_cnt + PERIOD_W'(1);
                     end
                  end
               end
            end
         end
      end

      assign tone_out[g] = tone_r;
      assign busy[g]     = busy_r;
      assign done[g]     = done_r;
   end

   logic [CW-1:0] ramp;

   // Mix: compare the count of high voices against a wrapping ramp.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ramp    <= '0;
         mix_out <= 1'b0;
      end else begin
         ramp    <= (ramp == CW'(CHANNELS - 1)) ? '0 : ramp + CW'(1);
         mix_out <= (popcount(tone_out) > SW'(ramp));
      end
   end

endmodule

// File: tb/tb_tone_bank.sv
// Scoreboard bench for tone_bank: a 4-voice and a 3-voice build share the
// write port and are compared each cycle against an arithmetic timing model.
module tb_tone_bank;

   localparam int     F  = 4;
   localparam int     C  = 4;
   localparam int     PW = 20;
   localparam int     DW = 16;
   localparam longint US = F;
   localparam longint MS = 1000 * F;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          wr_en = 1'b0;
   logic [1:0]    wr_chan = '0;
   logic [PW-1:0] wr_period = '0;
   logic [DW-1:0] wr_dur = '0;
   logic [3:0]    tone_out, busy, done;
   logic          mix_out;
   logic [2:0]    tone3, busy3, done3;
   logic          mix3;

   tone_bank #(.CLK_F(F), .CHANNELS(4), .PERIOD_W(PW), .DUR_W(DW)) dut (
      .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_chan(wr_chan),
      .wr_period(wr_period), .wr_dur(wr_dur), .tone_out(tone_out),
      .busy(busy), .done(done), .mix_out(mix_out)
   );

   tone_bank #(.CLK_F(F), .CHANNELS(3), .PERIOD_W(PW), .DUR_W(DW)) dut3 (
      .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_chan(wr_chan),
      .wr_period(wr_period), .wr_dur(wr_dur), .tone_out(tone3),
      .busy(busy3), .done(done3), .mix_out(mix3)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] tone;
      logic [3:0] busy;
      logic [3:0] done;
      logic       mix;
      logic [2:0] tone3;
      logic [2:0] busy3;
      logic [2:0] done3;
      logic       mix3;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         errors = 0;
   int         checks = 0;
   bit         running = 1'b0;
   longint     cyc = 0;
   bit         v_act[4];
   longint     v_w[4];
   longint     v_p[4];
   longint     v_d[4];
   logic [3:0] prev_tone = '0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s at cycle %0d: got %b, want %b", name, cyc, act, req);
      end
   endtask

   // Voice state at cycle m from the write time alone: ticks are counted
   // from the fixed timebase, toggles = ticks / period, expiry after D ms ticks.
   function automatic void voice_exp(input int v, input longint m,
                                     output logic t, output logic b, output logic d);
      longint k, j, jp;
      t = 1'b0; b = 1'b0; d = 1'b0;
      if (v_act[v]) begin
         k  = m / US - (v_w[v] + 1) / US;
         j  = m / MS - (v_w[v] + 1) / MS;
         jp = (m - 1) / MS - (v_w[v] + 1) / MS;
         if (v_d[v] != 0 && j >= v_d[v]) begin
            d = (j == v_d[v]) && (jp < v_d[v]);
         end else begin
            b = 1'b1;
            t = ((k / v_p[v]) % 2) == 1;
         end
      end
   endfunction

   task automatic push_exp();
      exp_t   e;
      logic   t, b, d;
      longint m;
      m = cyc + 1;
      e.tone = '0; e.busy = '0; e.done = '0;
      for (int v = 0; v < 4; v++) begin
         voice_exp(v, m, t, b, d);
         e.tone[v] = t;
         e.busy[v] = b;
         e.done[v] = d;
      end
      e.mix   = longint'($countones(prev_tone)) > ((m - 1) % C);
      e.tone3 = e.tone[2:0];
      e.busy3 = e.busy[2:0];
      e.done3 = e.done[2:0];
      e.mix3  = longint'($countones(prev_tone[2:0])) > ((m - 1) % 3);
      prev_tone = e.tone;
      exp_q.push_back(e);
   endtask

   // Called at a falling edge: drive one cycle of input, record the write, advance.
   task automatic step(input bit en, input int ch, input longint per, input longint dur);
      wr_en     = en;
      wr_chan   = 2'(ch);
      wr_period = PW'(per);
      wr_dur    = DW'(dur);
      if (en && ch < C) begin
         if (per != 0) begin
            v_act[ch] = 1'b1;
            v_w[ch]   = cyc;
            v_p[ch]   = per;
            v_d[ch]   = dur;
         end else begin
            v_act[ch] = 1'b0;
         end
      end
      push_exp();
      @(negedge CLK);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0);
   endtask

   task automatic model_clear();
      for (int v = 0; v < 4; v++) v_act[v] = 1'b0;
      prev_tone = '0;
      cyc = 0;
      exp_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tone"},  8'(tone_out), 8'd0);
      check({tag, "_busy"},  8'(busy),     8'd0);
      check({tag, "_done"},  8'(done),     8'd0);
      check({tag, "_mix"},   8'(mix_out),  8'd0);
      check({tag, "_tone3"}, 8'(tone3),    8'd0);
      check({tag, "_busy3"}, 8'(busy3),    8'd0);
      check({tag, "_done3"}, 8'(done3),    8'd0);
      check({tag, "_mix3"},  8'(mix3),     8'd0);
   endtask

   always @(posedge CLK) begin
      if (running) begin
         #2;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard at cycle %0d: got no expectation, want one queued", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("tone",  8'(tone_out), 8'(mon_e.tone));
            check("busy",  8'(busy),     8'(mon_e.busy));
            check("done",  8'(done),     8'(mon_e.done));
            check("mix",   8'(mix_out),  8'(mon_e.mix));
            check("tone3", 8'(tone3),    8'(mon_e.tone3));
            check("busy3", 8'(busy3),    8'(mon_e.busy3));
            check("done3", 8'(done3),    8'(mon_e.done3));
            check("mix3",  8'(mix3),     8'(mon_e.mix3));
         end
      end
   end

   initial begin
      int  ch, r;
      longint per, dur;
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check_all_zero("reset");
      @(negedge CLK);
      RST_N = 1'b1;
      model_clear();
      running = 1'b1;

      // untimed note and timed note
      step(1'b1, 0, 3, 0);
      idle(100);
      step(1'b1, 1, 5, 2);
      idle(int'(2 * MS) + 100);

      // stop then restart
      step(1'b1, 2, 2, 0);
      idle(30);
      step(1'b1, 2, 0, 0);
      idle(20);
      step(1'b1, 2, 2, 0);
      idle(40);

      // rewrite a timed voice in the very cycle it expires
      while (cyc % MS != 10) idle(1);
      step(1'b1, 1, 4, 1);
      while (cyc % MS != MS - 1) idle(1);
      step(1'b1, 1, 4, 0);
      idle(50);

      // channel 3 is out of range for the 3-voice build
      step(1'b1, 3, 7, 1);
      idle(int'(MS) + 50);

      // aligned writes so all voices toggle together, then only voices 0..1
      while (cyc % US != US - 1) idle(1);
      step(1'b1, 0, 3, 0);
      step(1'b1, 1, 3, 0);
      step(1'b1, 2, 3, 0);
      step(1'b1, 3, 3, 0);
      idle(60);
      step(1'b1, 2, 0, 0);
      step(1'b1, 3, 0, 0);
      idle(60);

      // full-width period and duration
      step(1'b1, 3, (1 << PW) - 1, (1 << DW) - 1);
      idle(50);

      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            ch = int'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 9));
            if (r == 0)      per = 0;
            else if (r == 9) per = longint'($urandom_range(1000, (1 << PW) - 1));
            else             per = r;
            dur = longint'($urandom_range(0, 3));
            step(1'b1, ch, per, dur);
         end else begin
            idle(1);
         end
      end

      // asynchronous reset while notes play
      step(1'b1, 0, 2, 0);
      step(1'b1, 1, 3, 0);
      idle(50);
      running = 1'b0;
      #2;
      RST_N = 1'b0;
      #1;
      check_all_zero("async_rst");
      repeat (3) @(posedge CLK);
      #1;
      check_all_zero("rst_hold");
      @(negedge CLK);
      RST_N = 1'b1;
      model_clear();
      running = 1'b1;
      idle(5000);
      running = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tone_bank.md
# tone_bank

Multi-channel square-wave tone generator: the parametrised successor to the single-channel tone block. It holds `CHANNELS` independent voices. Each voice has a programmable half-period in microseconds and an optional note duration in milliseconds. Each voice drives its own output. A 1-bit PWM mix of all voices feeds a single speaker pin. It sits between the sequencer/CPU write port and the audio pins on the board.

## Interface
Parameters:
- `CLK_F`, 32: clock frequency in MHz, integer ≥ 2.
- `CHANNELS`, 4: number of voices, 1..16.
- `PERIOD_W`, 20: width of the half-period field (µs).
- `DUR_W`, 16: width of the duration field (ms).
- `CW`, derived: clog2(CHANNELS), minimum 1.

Ports:
- `CLK` in 1: system clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `wr_en` in 1: one-cycle write strobe.
- `wr_chan` in CW: target voice.
- `wr_period` in PERIOD_W: half-period in µs; 0 = stop voice.
- `wr_dur` in DUR_W: note length in ms; 0 = sustain until rewritten.
- `tone_out` out CHANNELS: per-voice square wave.
- `busy` out CHANNELS: voice is sounding.
- `done` out CHANNELS: one-cycle pulse when a timed note expires.
- `mix_out` out 1: PWM sum of the voices.

## Operation
- Clock and reset: one clock domain (`CLK`); `RST_N` is asynchronous, active-low.
- Reset values:
  - `tone_out`, `busy`, `done`, `mix_out` = 0.
  - All counters, stored periods and stored durations = 0.
- µs tick:
  - Prescaler counts 0..CLK_F-1.
  - `us_tick` is asserted in the cycle the prescaler equals CLK_F-1.
  - Free-running; never reset by writes.
- ms tick:
  - Counter advances on `us_tick` over 0..999.
  - `ms_tick` = `us_tick` AND counter==999.
  - Global and free-running.
- Per-voice state: `period`, `hp_cnt` (PERIOD_W), `dur_cnt` (DUR_W), `timed` flag, `busy`.
- Write with `wr_period` ≠ 0 and `wr_chan` < CHANNELS (start note):
  - Load `period`; set `hp_cnt` = 0.
  - `tone_out` = 0, `busy` = 1.
  - `dur_cnt` = `wr_dur`; `timed` = (`wr_dur` ≠ 0).
  - Restarts a voice that is already playing; no `done` pulse for the aborted note.
- Write with `wr_period` = 0 (stop):
  - `busy` = 0, `tone_out` = 0.
  - No `done` pulse.
- Write with `wr_chan` ≥ CHANNELS: ignored.
- Tone generation, on `us_tick` for a busy voice:
  - If `hp_cnt` == `period`-1: `hp_cnt` = 0 and `tone_out` toggles.
  - Else `hp_cnt` increments.
  - Output frequency = 1e6 / (2·period) Hz.
- Duration, on `ms_tick` for a busy, timed voice:
  - Decrement `dur_cnt`.
  - On the transition 1→0: `busy` = 0, `tone_out` = 0, `done` = 1 for exactly one cycle.
- Collisions:
  - A write to a voice in the same cycle as its expiry: the write wins and `done` is not pulsed.
  - A write to a voice does not alter the other voices.
- Mix:
  - `ramp` counts 0..CHANNELS-1 every cycle, wrapping.
  - `mix_out` = (number of `tone_out` bits high) > `ramp`.
  - All voices high gives constant 1; none high gives 0.
  - Sum width: clog2(CHANNELS+1).
- Stored-value width: `period` and `dur_cnt` use full field width with no saturation. Maximum values play normally.

## Timing
- Write-to-output latency: all register effects are visible the cycle after `wr_en` (registered).
- First toggle: the first `tone_out` rising edge follows the `period`-th `us_tick` after the write. The phase jitter relative to the write is < 1 µs.
- Duration resolution: a note of D ms ends on the D-th `ms_tick` after the write. Actual length lies in (D-1, D] ms.
- `done` timing: asserted the cycle after the expiring `ms_tick`, in the same cycle `busy` falls.
- Reset mid-note: every output is 0 immediately (asynchronous). After `RST_N` rises, voices stay silent until written.
- `mix_out` updates every cycle from the registered `tone_out` values (one cycle lag).

## Test plan
Bench parameters: CLK_F=4, CHANNELS=4. µs = 4 clocks; ms = 4000 clocks.

1. Untimed note: write chan 0, period 3, dur 0. Required response:
   - `tone_out[0]` toggles every 12 clocks indefinitely (24-clock cycle).
   - `busy[0]` = 1; `done` never pulses.
2. Timed note: write chan 1, period 5, dur 2. Required response:
   - `busy[1]` falls on the 2nd `ms_tick` after the write.
   - `done[1]` pulses for exactly 1 cycle; `tone_out[1]` = 0 afterwards.
3. Stop and restart:
   - Write chan 2, period 2, dur 0; then write chan 2, period 0. Required response: `tone_out[2]` = 0 and `busy[2]` = 0, with no `done` pulse.
   - Rewrite chan 2 with period 2. Required response: the first rising edge comes after 2 `us_tick`s.
4. Collision and invalid write:
   - Write chan 1 in the cycle of its expiry. Required response: no `done` pulse; the new note plays.
   - Write with `wr_chan` = 4 (only checked when CHANNELS < 2^CW, so use a CHANNELS=3 build with `wr_chan` = 3). Required response: no state change.
5. Mix:
   - With `tone_out` = 4'b0011 held, `mix_out` is high 2 of every 4 cycles.
   - 4'b1111 gives constant 1; 4'b0000 gives constant 0.
6. Asynchronous reset: assert `RST_N` low mid-note. Required response:
   - All outputs go to 0 within the same cycle.
   - After release, all outputs remain 0 with no writes.
